// File: rtl/uart_digit_rx.sv
// ============================================================================
// uart_digit_rx : 8N1 UART receiver reporting bytes and ASCII decimal digits
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_digit_rx #(
  parameter int CLK_FREQ = 27000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       framing_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic [3:0]       digit_q, digit_d;
  logic             bv_q, bv_d;
  logic             dv_q, dv_d;
  logic             fe_q, fe_d;

  logic rx_s;
  logic is_digit;

  assign rx_s     = sync_q[1];
  // ASCII '0'..'9' share the upper nibble 0x3, so the low nibble is the value
  assign is_digit = (shift_q >= 8'h30) && (shift_q <= 8'h39);

  always_comb begin
    sync_d  = {sync_q[0], rxd};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    digit_d = digit_q;
    bv_d    = 1'b0;
    dv_d    = 1'b0;
    fe_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == C_HALF_LAST) begin
          cnt_d = '0;
          idx_d = 3'd0;
          // A line that is high again at mid-start-bit was only a glitch
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            bv_d    = 1'b1;
            state_d = S_IDLE;
            if (is_digit) begin
              digit_d = shift_q[3:0];
              dv_d    = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      // Hold off until the line returns high so a stuck-low line is not a 0x00 stream
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      digit_q <= 4'd0;
      bv_q    <= 1'b0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      digit_q <= digit_d;
      bv_q    <= bv_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  assign byte_data   = byte_q;
  assign byte_valid  = bv_q;
  assign digit       = digit_q;
  assign digit_valid = dv_q;
  assign framing_err = fe_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_digit_rx.sv
// ============================================================================
// tb_uart_digit_rx : self-checking bench for uart_digit_rx (16 clocks per bit)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_digit_rx;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HB       = CPB / 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd   = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [3:0] digit;
  logic       digit_valid;
  logic       framing_err;

  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_digit_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .digit      (digit),
    .digit_valid(digit_valid),
    .framing_err(framing_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: rx_s is rxd delayed two cycles; a frame is judged from the
  // rx_s values at fixed offsets from the first low cycle T.
  logic       m1 = 1'b1, m2 = 1'b1, rxs;
  bit         in_frame = 0, in_break = 0;
  int         t0, off;
  logic [7:0] mbits = 8'h00;
  logic [7:0] exp_byte = 8'h00;
  logic [3:0] exp_digit = 4'd0;
  logic       exp_bv = 1'b0, exp_dv = 1'b0, exp_fe = 1'b0;

  int         nbv = 0, ndv = 0, nfe = 0;
  int         dv_cyc[$];
  logic [3:0] dv_dig[$];

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, output int start_cyc);
    rxd       = 1'b0;
    start_cyc = cyc;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      hold(CPB);
    end
    rxd = stop;
    hold(CPB);
  endtask

  task automatic model_step();
    rxs = m2;
    m2  = m1;
    m1  = rxd;
    exp_bv = 1'b0;
    exp_dv = 1'b0;
    exp_fe = 1'b0;
    if (in_break) begin
      if (rxs) in_break = 0;
    end else if (!in_frame) begin
      if (!rxs) begin
        in_frame = 1;
        t0       = cyc;
      end
    end else begin
      off = cyc - t0;
      if (off == HB) begin
        if (rxs) in_frame = 0;
      end else if (off == HB + 9 * CPB) begin
        in_frame = 0;
        if (rxs) begin
          exp_byte = mbits;
          exp_bv   = 1'b1;
          if (mbits >= 8'h30 && mbits <= 8'h39) begin
            exp_digit = 4'(mbits - 8'h30);
            exp_dv    = 1'b1;
          end
        end else begin
          exp_fe   = 1'b1;
          in_break = 1;
        end
      end else if (off > HB && (off - HB) % CPB == 0) begin
        mbits[(off - HB) / CPB - 1] = rxs;
      end
    end
  endtask

  int s, s2, b_bv, b_dv, b_fe;
  logic [7:0] rb;
  logic       stop_bit;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          chk("rst_byte_data", byte_data, 8'h00);
          chk("rst_byte_valid", {7'd0, byte_valid}, 8'h00);
          chk("rst_digit", {4'd0, digit}, 8'h00);
          chk("rst_digit_valid", {7'd0, digit_valid}, 8'h00);
          chk("rst_framing_err", {7'd0, framing_err}, 8'h00);
          m1 = 1'b1; m2 = 1'b1;
          in_frame = 0; in_break = 0;
          exp_byte = 8'h00; exp_digit = 4'd0;
          exp_bv = 1'b0; exp_dv = 1'b0; exp_fe = 1'b0;
        end else begin
          chk("byte_data", byte_data, exp_byte);
          chk("byte_valid", {7'd0, byte_valid}, {7'd0, exp_bv});
          chk("digit", {4'd0, digit}, {4'd0, exp_digit});
          chk("digit_valid", {7'd0, digit_valid}, {7'd0, exp_dv});
          chk("framing_err", {7'd0, framing_err}, {7'd0, exp_fe});
          if (byte_valid) nbv++;
          if (framing_err) nfe++;
          if (digit_valid) begin
            ndv++;
            dv_cyc.push_back(cyc);
            dv_dig.push_back(digit);
          end
          model_step();
        end
      end
    join_none

    rst_n = 1'b0;
    rxd   = 1'b1;
    hold(4);
    rst_n = 1'b1;
    hold(20);

    // '5': pulse lands 2 (sync) + 152 (to stop centre) + 1 (register) cycles after rxd falls
    b_bv = nbv; b_dv = ndv; b_fe = nfe;
    send_byte(8'h35, 1'b1, s);
    hold(20);
    chk("five_bv_count", 8'(nbv - b_bv), 8'd1);
    chk("five_dv_count", 8'(ndv - b_dv), 8'd1);
    chk("five_fe_count", 8'(nfe - b_fe), 8'd0);
    chk("five_byte", byte_data, 8'h35);
    chk("five_digit", {4'd0, digit}, 8'd5);
    chk("five_latency", 8'(dv_cyc[$] - s), 8'd155);

    // 'A' updates the byte only
    b_bv = nbv; b_dv = ndv;
    send_byte(8'h41, 1'b1, s);
    hold(20);
    chk("A_bv_count", 8'(nbv - b_bv), 8'd1);
    chk("A_dv_count", 8'(ndv - b_dv), 8'd0);
    chk("A_byte", byte_data, 8'h41);
    chk("A_digit", {4'd0, digit}, 8'd5);

    // 3-cycle glitch, then a frame 10 cycles later must still decode
    b_bv = nbv; b_dv = ndv; b_fe = nfe;
    rxd = 1'b0; hold(3);
    rxd = 1'b1; hold(10);
    chk("glitch_no_pulse", 8'(nbv - b_bv + nfe - b_fe), 8'd0);
    send_byte(8'h31, 1'b1, s);
    hold(20);
    chk("glitch_next_byte", byte_data, 8'h31);
    chk("glitch_next_digit", {4'd0, digit}, 8'd1);

    // Bad stop bit, line held low, then '2'
    b_bv = nbv; b_dv = ndv; b_fe = nfe;
    send_byte(8'h37, 1'b0, s);
    rxd = 1'b0; hold(40);
    rxd = 1'b1; hold(16);
    chk("ferr_count", 8'(nfe - b_fe), 8'd1);
    chk("ferr_no_bv", 8'(nbv - b_bv), 8'd0);
    chk("ferr_digit_kept", {4'd0, digit}, 8'd1);
    send_byte(8'h32, 1'b1, s);
    hold(20);
    chk("after_break_digit", {4'd0, digit}, 8'd2);
    chk("after_break_dv", 8'(ndv - b_dv), 8'd1);

    // Reset in the middle of data bit 4 of '9'
    b_bv = nbv; b_dv = ndv; b_fe = nfe;
    rxd = 1'b0; hold(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'(8'h39 >> i);
      hold(CPB);
    end
    rxd = 1'b1;
    hold(HB);
    rst_n = 1'b0;
    hold(3);
    rst_n = 1'b1;
    hold(200);
    chk("abort_no_pulse", 8'(nbv - b_bv + ndv - b_dv + nfe - b_fe), 8'd0);
    chk("abort_byte_zero", byte_data, 8'h00);
    send_byte(8'h33, 1'b1, s);
    hold(20);
    chk("abort_then_digit", {4'd0, digit}, 8'd3);

    // '0' then '9' back to back
    b_dv = ndv;
    send_byte(8'h30, 1'b1, s);
    send_byte(8'h39, 1'b1, s2);
    hold(20);
    chk("b2b_dv_count", 8'(ndv - b_dv), 8'd2);
    chk("b2b_first", {4'd0, dv_dig[$-1]}, 8'd0);
    chk("b2b_second", {4'd0, dv_dig[$]}, 8'd9);
    chk("b2b_spacing", 8'(dv_cyc[$] - dv_cyc[$-1]), 8'd160);

    // Randomised traffic against the model
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        rxd = 1'b0; hold($urandom_range(1, 7));
        rxd = 1'b1; hold($urandom_range(10, 20));
      end
      rb       = ($urandom_range(0, 1) == 1) ? 8'(8'h30 + $urandom_range(0, 9))
                                             : 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 6) != 0);
      send_byte(rb, stop_bit, s);
      if (!stop_bit) begin
        rxd = 1'b0; hold($urandom_range(0, 30));
        rxd = 1'b1; hold($urandom_range(1, 20));
      end else begin
        hold($urandom_range(0, 30));
      end
    end
    rxd = 1'b1;
    hold(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
